pipelined_cla_subtractor: RTL

//   Two-stage pipelined subtractor with borrow in/out: D = A - B - Bin.

---
 rtl/pipelined_cla_subtractor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage pipelined subtractor: D = A - B - Bin, computed as A + ~B + ~Bin.
// The carry chain is split at the WIDTH/2 boundary. The lower half is resolved in
// stage 1 and the upper half in stage 2. Each stage uses a generate/propagate
// lookahead network. The valid/ready handshake on both sides buffers up to two
// results. in_ready is the only combinational input-to-output path (from out_ready).
// WIDTH must be even and >= 4.
module pipelined_cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int LO = WIDTH / 2;

  // Lookahead carries for one half: c[0] is the carry in, c[LO] the carry out.
  function automatic logic [LO:0] cla_carries(input logic [LO-1:0] a,
                                               input logic [LO-1:0] b,
                                               input logic          cin);
    logic [LO-1:0] g;
    logic [LO-1:0] p;
    logic [LO:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < LO; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return c;
  endfunction

  // Stage 1 registers
  logic          s1_valid_q;
  logic [LO-1:0] s1_d_lo_q;
  logic          s1_c_lo_q;
  logic [LO-1:0] s1_a_hi_q;
  logic [LO-1:0] s1_nb_hi_q;

  // Stage 2 (output) registers
  logic             out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;

  // Combinational half-adder results
  logic [LO-1:0] lo_p;
  logic [LO:0]   lo_c;
  logic [LO-1:0] hi_p;
  logic [LO:0]   hi_c;

  // Handshake
  logic s1_load;
  logic s2_load;

  // Lower half: A[LO-1:0] + ~B[LO-1:0] + ~Bin.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    lo_p = A[LO-1:0] ^ ~B[LO-1:0];
    lo_c = cla_carries(A[LO-1:0], ~B[LO-1:0], ~Bin);
  end

  // Upper half uses the registered lower-half carry as its carry in.
  always_comb begin
    hi_p = s1_a_hi_q ^ s1_nb_hi_q;
    hi_c = cla_carries(s1_a_hi_q, s1_nb_hi_q, s1_c_lo_q);
  end

  // The output stage loads when it is empty or being drained.
  // Stage 1 loads when it is empty or moving into stage 2.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q  || s2_load;
  assign in_ready = s1_load;

  // Stage 1: capture the lower-half sum and carry, and the upper operand halves.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: data registers are reset too, so outputs and state are defined from reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_d_lo_q  <= '0;
      s1_c_lo_q  <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_nb_hi_q <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_d_lo_q  <= lo_p ^ lo_c[LO-1:0];
        s1_c_lo_q  <= lo_c[LO];
        s1_a_hi_q  <= A[WIDTH-1:LO];
        s1_nb_hi_q <= ~B[WIDTH-1:LO];
      end
    end
  end

  // Stage 2: finish the upper half and register the result, borrow and overflow.
  // Data holds through bubbles, so the outputs keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        d_q    <= {hi_p ^ hi_c[LO-1:0], s1_d_lo_q};
        bout_q <= ~hi_c[LO];
        ovf_q  <= hi_c[LO] ^ hi_c[LO-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
